// File: rtl/fir4_inv_rec_if.sv
// Sample bus for the inverse moving-sum reconstructor: sum stream in, samples out.
// The master drives sums and resync; the slave returns samples and the error flag.
interface fir4_inv_rec_if #(
   parameter int unsigned w = 16
);
   logic [w+1:0] y;
   logic         y_valid;
   logic         resync;
   logic [w-1:0] x;
   logic         x_valid;
   logic         err;

   modport master (
      output y, y_valid, resync,
      input  x, x_valid, err
   );

   modport slave (
      input  y, y_valid, resync,
      output x, x_valid, err
   );
endinterface

// File: rtl/fir4_inv_rec.sv
// Recursive inverse of the 4-tap moving sum: x[k] = y[k] - y[k-1] + x[k-4].
// Optional range checker with a sticky error state is built when FIR4_INV_ERRCHK_EN is defined.
module fir4_inv_rec #(
   parameter int unsigned w = 16
) (
   input  logic           clk,
   input  logic           reset,
   fir4_inv_rec_if.slave  bus
);

   typedef enum logic {
      RUN = 1'b0,
      ERR = 1'b1
   } state_t;

`ifdef FIR4_INV_ERRCHK_EN
   localparam int unsigned YW = w + 2;
   localparam int unsigned DW = w + 4;
`else
   // Without the checker only the low w bits of the difference matter.
   localparam int unsigned YW = w;
   localparam int unsigned DW = w;
`endif

   state_t         state, state_n;
   logic [YW-1:0]  yprev, yprev_n;
   logic [w-1:0]   h   [4];
   logic [w-1:0]   h_n [4];
   logic [w-1:0]   x_r, x_n;
   logic           xv_r, xv_n;
   logic [DW-1:0]  d;
   logic           bad;

`ifdef FIR4_INV_ERRCHK_EN
   logic           err_r, err_n;

   assign d   = {2'b00, bus.y} - {2'b00, yprev} + {4'b0000, h[3]};
   assign bad = d[DW-1] | (|d[DW-2:w]);
   assign bus.err = err_r;
`else
   assign d   = bus.y[w-1:0] - yprev + h[3];
   assign bad = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.x       = x_r;
   assign bus.x_valid = xv_r;

   always_comb begin
      state_n = state;
      yprev_n = yprev;
      h_n     = h;
      x_n     = x_r;
      xv_n    = 1'b0;
`ifdef FIR4_INV_ERRCHK_EN
      err_n   = err_r;
`endif
      if (bus.resync) begin
         state_n = RUN;
         yprev_n = '0;
         h_n     = '{default: '0};
         x_n     = '0;
`ifdef FIR4_INV_ERRCHK_EN
         err_n   = 1'b0;
`endif
      end else if (bus.y_valid && state == RUN) begin
         if (bad) begin
            // Offending sample is dropped; outputs and history keep pre-error values.
            state_n = ERR;
`ifdef FIR4_INV_ERRCHK_EN
            err_n   = 1'b1;
`endif
         end else begin
            x_n     = d[w-1:0];
            xv_n    = 1'b1;
            yprev_n = bus.y[YW-1:0];
            h_n[3]  = h[2];
            h_n[2]  = h[1];
            h_n[1]  = h[0];
            h_n[0]  = d[w-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         yprev <= '0;
         for (int unsigned i = 0; i < 4; i++) h[i] <= '0;
         x_r   <= '0;
         xv_r  <= 1'b0;
`ifdef FIR4_INV_ERRCHK_EN
         err_r <= 1'b0;
`endif
      end else begin
         state <= state_n;
         yprev <= yprev_n;
         for (int unsigned i = 0; i < 4; i++) h[i] <= h_n[i];
         x_r   <= x_n;
         xv_r  <= xv_n;
`ifdef FIR4_INV_ERRCHK_EN
         err_r <= err_n;
`endif
      end
   end

endmodule

// File: tb/tb_fir4_inv_rec.sv
// Scoreboard bench for fir4_inv_rec (w=16): expected samples are queued at drive time
// and popped whenever the DUT pulses x_valid.
module tb_fir4_inv_rec;

   localparam int unsigned W = 16;

   logic clk = 1'b0;
   logic reset;

   fir4_inv_rec_if #(.w(W)) bus ();

   fir4_inv_rec #(.w(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [W-1:0] sbq [$];
   logic [W-1:0] xm  [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: drive at negedge, sample 1 time unit after the rising edge.
   task automatic step(input logic [W+1:0] yv, input logic v, input logic rs, input logic expv);
      @(negedge clk);
      bus.y       = yv;
      bus.y_valid = v;
      bus.resync  = rs;
      @(posedge clk);
      #1;
      check("x_valid", {31'd0, bus.x_valid}, {31'd0, expv});
      if (bus.x_valid) begin
         if (sbq.size() == 0) check("sb_underflow", 32'd1, 32'd0);
         else check("x", {16'd0, bus.x}, {16'd0, sbq.pop_front()});
      end
      bus.y_valid = 1'b0;
      bus.resync  = 1'b0;
   endtask

   task automatic send(input logic [W+1:0] yv, input logic [W-1:0] xexp);
      sbq.push_back(xexp);
      step(yv, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic do_resync();
      step('0, 1'b0, 1'b1, 1'b0);
      check("resync_x", {16'd0, bus.x}, 32'd0);
      check("resync_err", {31'd0, bus.err}, 32'd0);
      for (int i = 0; i < 4; i++) xm[i] = '0;
   endtask

   // Forward moving-sum model: new sample in, sum out.
   function automatic logic [W+1:0] fwd(input logic [W-1:0] xn);
      logic [W+1:0] s;
      s = {2'b00, xn} + {2'b00, xm[0]} + {2'b00, xm[1]} + {2'b00, xm[2]};
      xm[3] = xm[2];
      xm[2] = xm[1];
      xm[1] = xm[0];
      xm[0] = xn;
      return s;
   endfunction

   initial begin
      logic [W-1:0] xs;
      bus.y = '0;
      bus.y_valid = 1'b0;
      bus.resync = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) xm[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_x", {16'd0, bus.x}, 32'd0);
      check("rst_xv", {31'd0, bus.x_valid}, 32'd0);
      check("rst_err", {31'd0, bus.err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Basic sequence
      send(18'd1, 16'd1);
      send(18'd3, 16'd2);
      send(18'd6, 16'd3);
      send(18'd10, 16'd4);
      send(18'd14, 16'd5);
      step('0, 1'b0, 1'b0, 1'b0);
      check("hold_after_basic", {16'd0, bus.x}, 32'd5);

      // Full-scale
      do_resync();
      send(18'd65535, 16'd65535);
      send(18'd131070, 16'd65535);
      send(18'd196605, 16'd65535);
      send(18'd262140, 16'd65535);
      send(18'd262140, 16'd65535);
      check("fullscale_err", {31'd0, bus.err}, 32'd0);

      // Gaps between samples 2 and 3
      do_resync();
      send(18'd1, 16'd1);
      send(18'd3, 16'd2);
      for (int i = 0; i < 3; i++) begin
         step(18'd99, 1'b0, 1'b0, 1'b0);
         check("gap_hold", {16'd0, bus.x}, 32'd2);
      end
      send(18'd6, 16'd3);
      send(18'd10, 16'd4);
      send(18'd14, 16'd5);

      // Random in-range samples through the forward model, with random idle cycles
      do_resync();
      for (int i = 0; i < 40; i++) begin
         xs = W'($urandom_range(0, 65535));
         if ($urandom_range(0, 3) == 0) step('0, 1'b0, 1'b0, 1'b0);
         send(fwd(xs), xs);
      end

      // Out-of-range sum: y = 1 then y = 0 gives d = -1
      do_resync();
      send(18'd1, 16'd1);
`ifdef FIR4_INV_ERRCHK_EN
      step(18'd0, 1'b1, 1'b0, 1'b0);
      check("err_set", {31'd0, bus.err}, 32'd1);
      check("err_x_hold", {16'd0, bus.x}, 32'd1);
      step(18'd5, 1'b1, 1'b0, 1'b0);
      check("err_sticky", {31'd0, bus.err}, 32'd1);
      check("err_ignore_x", {16'd0, bus.x}, 32'd1);
      do_resync();
      send(18'd7, 16'd7);
      check("err_cleared", {31'd0, bus.err}, 32'd0);
`else
      send(18'd0, 16'd65535);
      check("no_err", {31'd0, bus.err}, 32'd0);
`endif

      // Asynchronous reset between edges
      do_resync();
      send(18'd1, 16'd1);
      send(18'd3, 16'd2);
      #2;
      reset = 1'b1;
      #1;
      check("async_x", {16'd0, bus.x}, 32'd0);
      check("async_xv", {31'd0, bus.x_valid}, 32'd0);
      check("async_err", {31'd0, bus.err}, 32'd0);
      reset = 1'b0;
      send(18'd5, 16'd5);

      step('0, 1'b0, 1'b0, 1'b0);
      check("sb_drain", sbq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
